// File: rtl/int_gen_responder_pkg.sv
// Shared types and constants for the interrupt-generator responder.
// Holds the FSM state encoding and the default acknowledge address.
`timescale 1ns/1ps
package int_gen_responder_pkg;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ASSERT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_ACK_ADDR = 32'h0000_7F20;

endpackage

// File: rtl/int_gen_table.sv
// Trigger table: NUM_TRIG entries of {pc, delay, valid}.
// One write port, a combinational read at rd_idx, and the valid bits exported as a vector.
`timescale 1ns/1ps
module int_gen_table #(
    parameter int NUM_TRIG = 4,
    parameter int DELAY_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(NUM_TRIG)-1:0] wr_idx,
    input  logic [31:0]                 wr_pc,
    input  logic [DELAY_W-1:0]          wr_delay,
    input  logic                        wr_valid,
    input  logic [$clog2(NUM_TRIG)-1:0] rd_idx,
    output logic [31:0]                 rd_pc,
    output logic [DELAY_W-1:0]          rd_delay,
    output logic                        rd_valid,
    output logic [NUM_TRIG-1:0]         valid_vec
);
    localparam int IDX_W = $clog2(NUM_TRIG);

    logic [31:0]        pc_arr    [NUM_TRIG];
    logic [DELAY_W-1:0] delay_arr [NUM_TRIG];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRIG; gi++) begin : g_entry
            logic [31:0]        pc_reg;
            logic [DELAY_W-1:0] delay_reg;
            logic               valid_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pc_reg    <= '0;
                    delay_reg <= '0;
                    valid_reg <= 1'b0;
                end else if (we && (wr_idx == IDX_W'(gi))) begin
                    pc_reg    <= wr_pc;
                    delay_reg <= wr_delay;
                    valid_reg <= wr_valid;
                end
            end

            assign pc_arr[gi]    = pc_reg;
            assign delay_arr[gi] = delay_reg;
            assign valid_vec[gi] = valid_reg;
        end
    endgenerate

    assign rd_pc    = pc_arr[rd_idx];
    assign rd_delay = delay_arr[rd_idx];
    assign rd_valid = valid_vec[rd_idx];

endmodule

// File: rtl/int_gen_responder.sv
// Device-side interrupt generator: raises `interrupt` at programmed trigger PCs and holds it until acked.
// Optional ack watchdog is enabled by defining INTGEN_TIMEOUT_EN.
`timescale 1ns/1ps
module int_gen_responder
    import int_gen_responder_pkg::*;
#(
    parameter int          NUM_TRIG = 4,
    parameter logic [31:0] ACK_ADDR = DEFAULT_ACK_ADDR,
    parameter int          DELAY_W  = 8,
    parameter int          TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 macroscopic_pc,
    input  logic [31:0]                 m_int_addr,
    input  logic [3:0]                  m_int_byteen,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_TRIG)-1:0] cfg_idx,
    input  logic [31:0]                 cfg_pc,
    input  logic [DELAY_W-1:0]          cfg_delay,
    input  logic                        cfg_valid,
    output logic                        interrupt,
    output logic [7:0]                  fired_cnt,
    output logic                        spurious_ack,
    output logic                        timeout_err
);
    localparam int IDX_W = $clog2(NUM_TRIG);

    state_t             state_reg, state_next;
    logic [DELAY_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [7:0]         fired_reg, fired_next;
    logic               interrupt_reg;
    logic               spurious_reg;

    logic [31:0]        rd_pc;
    logic [DELAY_W-1:0] rd_delay;
    logic               rd_valid;
    logic [NUM_TRIG-1:0] valid_vec;

    logic               ack;
    logic               match;
    logic               advance;
    logic [IDX_W-1:0]   ptr_inc;
    logic               next_valid;
    logic               rearm;

    int_gen_table #(
        .NUM_TRIG (NUM_TRIG),
        .DELAY_W  (DELAY_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .we        (cfg_we),
        .wr_idx    (cfg_idx),
        .wr_pc     (cfg_pc),
        .wr_delay  (cfg_delay),
        .wr_valid  (cfg_valid),
        .rd_idx    (ptr_reg),
        .rd_pc     (rd_pc),
        .rd_delay  (rd_delay),
        .rd_valid  (rd_valid),
        .valid_vec (valid_vec)
    );

    // Byte offset within the word is ignored: any store to the ack word counts.
    assign ack   = ((m_int_addr & ~32'h3) == (ACK_ADDR & ~32'h3)) && (m_int_byteen != 4'b0000);
    assign match = rd_valid && (macroscopic_pc == rd_pc);

    // A config write landing in the same cycle wins over the stored valid bit.
    assign ptr_inc    = ptr_reg + 1'b1;
    assign next_valid = (cfg_we && (cfg_idx == ptr_inc)) ? cfg_valid : valid_vec[ptr_inc];
    assign rearm      = cfg_we && (cfg_idx == ptr_reg) && cfg_valid;

`ifdef INTGEN_TIMEOUT_EN
    logic [31:0] wdog_reg, wdog_next;
    logic        timeout_reg, timeout_next;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        fired_next = fired_reg;
        advance    = 1'b0;
`ifdef INTGEN_TIMEOUT_EN
        wdog_next    = '0;
        timeout_next = timeout_reg;
`endif
        case (state_reg)
            ST_ARMED: begin
                if (match) begin
                    if (rd_delay == '0) begin
                        state_next = ST_ASSERT;
                    end else begin
                        cnt_next   = rd_delay;
                        state_next = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_reg <= DELAY_W'(1)) begin
                    state_next = ST_ASSERT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_ASSERT: begin
                if (ack) begin
                    advance    = 1'b1;
                    fired_next = fired_reg + 8'd1;
                end
`ifdef INTGEN_TIMEOUT_EN
                else if (wdog_reg == 32'(TIMEOUT - 1)) begin
                    advance      = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 32'd1;
                end
`endif
                if (advance) begin
                    ptr_next   = ptr_inc;
                    state_next = next_valid ? ST_ARMED : ST_DONE;
                end
            end
            ST_DONE: begin
                if (rearm) begin
                    state_next = ST_ARMED;
                end
            end
            default: state_next = ST_ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_ARMED;
            cnt_reg       <= '0;
            ptr_reg       <= '0;
            fired_reg     <= '0;
            interrupt_reg <= 1'b0;
            spurious_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            fired_reg     <= fired_next;
            interrupt_reg <= (state_next == ST_ASSERT);
            if (ack && (state_reg != ST_ASSERT)) begin
                spurious_reg <= 1'b1;
            end
        end
    end

`ifdef INTGEN_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wdog_reg    <= wdog_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout_err = timeout_reg;
`else
    assign timeout_err = 1'b0;
`endif

    assign interrupt    = interrupt_reg;
    assign fired_cnt    = fired_reg;
    assign spurious_ack = spurious_reg;

endmodule

// File: tb/tb_int_gen_responder.sv
// Directed bench for int_gen_responder: immediate/delayed triggers, table walk, spurious acks, async reset, watchdog.
// Watchdog expectations follow whether INTGEN_TIMEOUT_EN is defined for the build.
`timescale 1ns/1ps
module tb_int_gen_responder;
    localparam int NUM_TRIG = 4;
    localparam int DELAY_W  = 8;
    localparam int TIMEOUT  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        macroscopic_pc;
    logic [31:0]        m_int_addr;
    logic [3:0]         m_int_byteen;
    logic               cfg_we;
    logic [1:0]         cfg_idx;
    logic [31:0]        cfg_pc;
    logic [DELAY_W-1:0] cfg_delay;
    logic               cfg_valid;
    logic               interrupt;
    logic [7:0]         fired_cnt;
    logic               spurious_ack;
    logic               timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    int_gen_responder #(
        .NUM_TRIG (NUM_TRIG),
        .ACK_ADDR (32'h0000_7F20),
        .DELAY_W  (DELAY_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .macroscopic_pc (macroscopic_pc),
        .m_int_addr     (m_int_addr),
        .m_int_byteen   (m_int_byteen),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_pc         (cfg_pc),
        .cfg_delay      (cfg_delay),
        .cfg_valid      (cfg_valid),
        .interrupt      (interrupt),
        .fired_cnt      (fired_cnt),
        .spurious_ack   (spurious_ack),
        .timeout_err    (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        macroscopic_pc = 32'h0;
        m_int_addr     = 32'h0;
        m_int_byteen   = 4'b0000;
        cfg_we         = 1'b0;
        cfg_idx        = 2'd0;
        cfg_pc         = 32'h0;
        cfg_delay      = '0;
        cfg_valid      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic write_entry(input logic [1:0] idx, input logic [31:0] pc,
                               input logic [7:0] dly, input logic vld);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_pc    = pc;
        cfg_delay = dly;
        cfg_valid = vld;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic store(input logic [31:0] addr, input logic [3:0] be);
        m_int_addr   = addr;
        m_int_byteen = be;
        tick();
        m_int_addr   = 32'h0;
        m_int_byteen = 4'b0000;
    endtask

    initial begin
        int lat;
        bit found;

        // Reset state
        idle_inputs();
        reset = 1'b0;
        #2;
        check("reset_interrupt", {31'h0, interrupt}, 32'h0);
        check("reset_fired_cnt", {24'h0, fired_cnt}, 32'h0);
        check("reset_spurious", {31'h0, spurious_ack}, 32'h0);
        check("reset_timeout", {31'h0, timeout_err}, 32'h0);
        do_reset();

        // Immediate trigger, ack, then DONE and re-arm via entry 1
        write_entry(2'd0, 32'h3008, 8'd0, 1'b1);
        macroscopic_pc = 32'h3008;
        tick();
        check("imm_rise", {31'h0, interrupt}, 32'h1);
        macroscopic_pc = 32'h0;
        store(32'h7F20, 4'b1111);
        check("imm_ack_fall", {31'h0, interrupt}, 32'h0);
        check("imm_fired_cnt", {24'h0, fired_cnt}, 32'h1);
        macroscopic_pc = 32'h300C;
        tick();
        tick();
        check("done_ignores_pc", {31'h0, interrupt}, 32'h0);
        write_entry(2'd1, 32'h300C, 8'd0, 1'b1);
        tick();
        check("done_rearm_fire", {31'h0, interrupt}, 32'h1);
        macroscopic_pc = 32'h0;
        store(32'h7F20, 4'b1111);
        check("rearm_fired_cnt", {24'h0, fired_cnt}, 32'h2);

        // Delayed trigger: PC changes after the match cycle must not matter
        do_reset();
        write_entry(2'd0, 32'h3010, 8'd5, 1'b1);
        macroscopic_pc = 32'h3010;
        lat   = 0;
        found = 1'b0;
        for (int e = 1; e <= 20 && !found; e++) begin
            tick();
            if (e == 1) macroscopic_pc = 32'h0;
            if (interrupt) begin
                lat   = e;
                found = 1'b1;
            end
        end
        check("delay5_latency", lat, 32'd6);

        // Four entries fire in table order and the pointer wraps
        do_reset();
        for (int i = 0; i < 4; i++) begin
            write_entry(2'(i), 32'h3000 + 32'(4 * i), 8'd0, 1'b1);
        end
        macroscopic_pc = 32'h3004;
        tick();
        check("out_of_order_pc", {31'h0, interrupt}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            macroscopic_pc = 32'h3000 + 32'(4 * i);
            tick();
            check($sformatf("walk_rise_%0d", i), {31'h0, interrupt}, 32'h1);
            macroscopic_pc = 32'h0;
            store(32'h7F20, 4'b1111);
            check($sformatf("walk_fall_%0d", i), {31'h0, interrupt}, 32'h0);
            check($sformatf("walk_cnt_%0d", i), {24'h0, fired_cnt}, 32'(i + 1));
        end
        macroscopic_pc = 32'h3000;
        tick();
        check("wrap_refire_entry0", {31'h0, interrupt}, 32'h1);

        // Spurious ack in ARMED; non-ack stores while asserted
        do_reset();
        write_entry(2'd0, 32'h3008, 8'd0, 1'b1);
        store(32'h7F20, 4'b0001);
        check("spurious_set", {31'h0, spurious_ack}, 32'h1);
        check("spurious_no_irq", {31'h0, interrupt}, 32'h0);
        macroscopic_pc = 32'h3008;
        tick();
        check("assert_rise", {31'h0, interrupt}, 32'h1);
        macroscopic_pc = 32'h0;
        store(32'h7F24, 4'b1111);
        check("wrong_addr_hold", {31'h0, interrupt}, 32'h1);
        store(32'h7F20, 4'b0000);
        check("zero_byteen_hold", {31'h0, interrupt}, 32'h1);
        check("no_ack_cnt", {24'h0, fired_cnt}, 32'h0);
        check("spurious_sticky", {31'h0, spurious_ack}, 32'h1);

        // Asynchronous reset between clock edges while asserted
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_drop", {31'h0, interrupt}, 32'h0);
        @(posedge clk);
        #1;
        reset          = 1'b1;
        macroscopic_pc = 32'h3008;
        tick();
        tick();
        tick();
        check("no_refire_after_reset", {31'h0, interrupt}, 32'h0);
        write_entry(2'd0, 32'h3008, 8'd0, 1'b1);
        tick();
        check("refire_after_reprogram", {31'h0, interrupt}, 32'h1);
        macroscopic_pc = 32'h0;

        // Watchdog: with the feature the line drops after TIMEOUT cycles
        repeat (TIMEOUT - 1) tick();
        check("hold_before_limit", {31'h0, interrupt}, 32'h1);
        tick();
`ifdef INTGEN_TIMEOUT_EN
        check("timeout_drop", {31'h0, interrupt}, 32'h0);
        check("timeout_err_set", {31'h0, timeout_err}, 32'h1);
        check("timeout_no_count", {24'h0, fired_cnt}, 32'h0);
`else
        check("no_wdog_hold", {31'h0, interrupt}, 32'h1);
        check("no_wdog_err", {31'h0, timeout_err}, 32'h0);
        check("no_wdog_count", {24'h0, fired_cnt}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
